// File: rtl/iiitb_lfsr_pkg.sv
// iiitb_lfsr_pkg
// Shared definitions for the LFSR scheduler family.
//   LFSR_W       : width of the shared LFSR state (5 bits)
//   TAP_HI/TAP_LO: feedback taps for x^5+x^3+1 with a left-shifting register
//   DEFAULT_SEED : power-on LFSR value, must be nonzero
//   sched_state_e: scheduler FSM states
package iiitb_lfsr_pkg;

   localparam int LFSR_W = 5;
   localparam int TAP_HI = 4;
   localparam int TAP_LO = 2;

   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 5'b11111;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } sched_state_e;

endpackage

// File: rtl/iiitb_rr_arb.sv
// iiitb_rr_arb
// Combinational round-robin arbiter. Searches the request vector cyclically
// starting at the pointer and returns a one-hot winner together with the
// pointer value that should follow if this winner is actually granted.
//   req      : request vector, one bit per requester
//   ptr      : index the search starts from (highest priority this cycle)
//   grant    : one-hot winner, all zero when no request is present
//   next_ptr : index just after the winner, wrapping at NREQ; equals ptr
//              when nothing is requested
module iiitb_rr_arb #(
   parameter int NREQ  = 4,
   parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [PTR_W-1:0] next_ptr
);

   // One extra bit so ptr+i can be wrapped by subtraction without relying on
   // NREQ being a power of two.
   localparam int SUM_W = PTR_W + 1;

   logic [SUM_W-1:0] sum;
   logic [PTR_W-1:0] idx;
   logic             found;

   // Walk the requesters in priority order starting at ptr. The first set
   // request wins; later hits are ignored through the found flag, which keeps
   // the grant strictly one-hot.
   always_comb begin
      grant    = '0;
      next_ptr = ptr;
      found    = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int i = 0; i < NREQ; i++) begin
         sum = {1'b0, ptr} + SUM_W'(i);
         if (sum >= SUM_W'(NREQ)) begin
            sum = sum - SUM_W'(NREQ);
         end
         idx = sum[PTR_W-1:0];
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            if (idx == PTR_W'(NREQ - 1)) begin
               next_ptr = '0;
            end else begin
               next_ptr = idx + PTR_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/iiitb_lfsr_sched.sv
// iiitb_lfsr_sched
// Round-robin scheduler sharing one 5-bit maximal-length LFSR among NREQ
// requesters. Each grant produces a burst of BURST pseudo-random words on a
// valid/ready stream; the LFSR only advances on accepted beats, so the
// sequence runs on seamlessly across bursts and requesters.
//   clk, reset : clock and asynchronous active-high reset
//   req        : level request per requester
//   grant      : one-hot grant, held for the whole burst
//   rnd_valid  : beat valid (high in RUN)
//   rnd_ready  : consumer accepts the current beat
//   rnd_data   : current LFSR state
//   rnd_last   : final beat of the burst
//   cfg_load   : single-cycle seed load strobe (honoured only in IDLE)
//   cfg_seed   : seed value for cfg_load
//   cfg_err    : one-cycle pulse when a load is rejected
//   busy       : high whenever the scheduler is not IDLE
module iiitb_lfsr_sched
   import iiitb_lfsr_pkg::*;
#(
   parameter int                NREQ  = 4,
   parameter int                BURST = 4,
   parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   output logic [NREQ-1:0]   grant,
   output logic              rnd_valid,
   input  logic              rnd_ready,
   output logic [LFSR_W-1:0] rnd_data,
   output logic              rnd_last,
   input  logic              cfg_load,
   input  logic [LFSR_W-1:0] cfg_seed,
   output logic              cfg_err,
   output logic              busy
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

   sched_state_e      state_q, state_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic              cfg_err_q, cfg_err_d;

   logic [LFSR_W-1:0] lfsr_step;
   logic [NREQ-1:0]   arb_grant;
   logic [PTR_W-1:0]  arb_next_ptr;

   // Left-shifting Fibonacci LFSR for x^5+x^3+1. From any nonzero state it
   // cycles through all 31 nonzero values and never reaches zero.
   assign lfsr_step = {lfsr_q[LFSR_W-2:0], lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO]};

   // The arbiter is purely combinational; its result is only committed when
   // the FSM actually issues a grant, which is also the only time the
   // round-robin pointer moves.
   iiitb_rr_arb #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req      (req),
      .ptr      (ptr_q),
      .grant    (arb_grant),
      .next_ptr (arb_next_ptr)
   );

   // Next-state logic for the whole scheduler. In IDLE a seed load takes
   // priority over arbitration, so a request arriving with a load strobe is
   // serviced one cycle later. In RUN every accepted beat steps the LFSR and
   // the beat counter; the accepted last beat returns to IDLE and drops the
   // grant on the same edge. Load strobes seen in RUN are rejected and
   // reported without touching the LFSR.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      lfsr_d    = lfsr_q;
      cfg_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (cfg_load) begin
               if (cfg_seed != '0) begin
                  lfsr_d = cfg_seed;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end else if (|req) begin
               grant_d = arb_grant;
               ptr_d   = arb_next_ptr;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            cfg_err_d = cfg_load;
            if (rnd_ready) begin
               lfsr_d = lfsr_step;
               if (cnt_q == LAST_BEAT) begin
                  state_d = IDLE;
                  grant_d = '0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // All scheduler state lives in this one register bank. Reset puts the
   // LFSR back to SEED and the pointer to 0 so requester 0 wins first; any
   // burst in flight is simply abandoned.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         cnt_q     <= '0;
         ptr_q     <= '0;
         lfsr_q    <= SEED;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         lfsr_q    <= lfsr_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // Stream handshake outputs are decoded straight from the state and
   // counter flops, so they hold steady under backpressure.
   assign rnd_valid = (state_q == RUN);
   assign rnd_last  = (state_q == RUN) && (cnt_q == LAST_BEAT);
   assign rnd_data  = lfsr_q;
   assign grant     = grant_q;
   assign cfg_err   = cfg_err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: doc/iiitb_lfsr_sched.md
# iiitb_lfsr_sched

Round-robin scheduler that shares a single 5-bit maximal-length LFSR among NREQ requesters. Each grant yields a fixed-length burst of pseudo-random words over a valid/ready stream. The block owns the LFSR state register, seed loading and sequencing. It sits between the pattern consumers and the LFSR datapath, replacing free-running per-consumer LFSRs.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- BURST, 4: beats per grant (1..16).
- SEED, 5'b11111: LFSR reset value; must be nonzero.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears the block immediately.
- req  in  NREQ  level request per requester.
- grant  out  NREQ  one-hot grant, held for the whole burst.
- rnd_valid  out  1  beat valid.
- rnd_ready  in  1  consumer accepts beat.
- rnd_data  out  5  current LFSR state.
- rnd_last  out  1  final beat of the burst.
- cfg_load  in  1  single-cycle seed-load strobe.
- cfg_seed  in  5  seed value.
- cfg_err  out  1  one-cycle pulse on a rejected load.
- busy  out  1  high whenever state is not IDLE.

## Operation
- LFSR: left shift, next = {q[3:0], q[4]^q[2]} (x^5+x^3+1). Period is 31, and all-zero is unreachable from any nonzero state.
- FSM states: IDLE, RUN.
- IDLE:
  - cfg_load with nonzero cfg_seed: LFSR <= cfg_seed; stay IDLE.
  - cfg_load with zero seed: cfg_err pulses; LFSR unchanged.
  - Otherwise, if any req bit is set, the arbiter picks a winner; grant <= one-hot winner; beat counter <= 0; go to RUN.
  - cfg_load has priority over arbitration in the same cycle. Requests are serviced the following cycle.
- RUN:
  - rnd_valid=1; rnd_data=LFSR state.
  - On rnd_valid&rnd_ready, the LFSR steps and the counter increments.
  - rnd_last=1 when counter==BURST-1. Its accepted beat returns the FSM to IDLE, and grant clears on the same edge.
- Round-robin:
  - A pointer holds the index after the last winner; the search is cyclic from the pointer.
  - Reset pointer = 0, giving req[0] highest priority.
  - The pointer updates only when a grant is issued.
- A requester dropping req mid-burst does not abort the burst; the grant holds until the last beat.
- cfg_load in RUN: ignored, cfg_err pulses, and the LFSR continues undisturbed.
- The LFSR never steps outside an accepted beat, so the sequence continues across bursts and requesters.

## Timing
- Reset values:
  - grant=0, rnd_valid=0, rnd_last=0, cfg_err=0, busy=0.
  - rnd_data=SEED, RR pointer=0, state=IDLE.
- Grant latency: req seen in IDLE at edge t gives grant and rnd_valid high after edge t (next cycle).
- Throughput:
  - With rnd_ready tied high, BURST beats arrive in BURST consecutive cycles.
  - One IDLE cycle follows between bursts, so the minimum cost is BURST+1 cycles per grant.
- Backpressure: rnd_data, rnd_last and grant stay stable while rnd_valid&!rnd_ready.
- Load latency: new seed appears on rnd_data the cycle after cfg_load.
- Reset mid-burst: outputs drop asynchronously. The LFSR returns to SEED and the pointer to 0; the burst is lost.
- cfg_err is a single-cycle pulse per rejected strobe.
- All outputs are registered except rnd_valid and rnd_last, which are decoded from state and counter flops.

## Structure
- Shared package iiitb_lfsr_pkg:
  - LFSR width constant (5) and tap positions (4, 2).
  - Default seed 5'b11111.
  - FSM state enum {IDLE, RUN}.
- Sub-module iiitb_rr_arb: combinational one-hot round-robin pick from req and pointer, plus the next-pointer output. It is reused by other shared-resource schedulers.
- The LFSR next-state function is an inline assign; it is not a module.

## Test plan
- Reset, then req=4'b0001, ready=1:
  - grant=0001 next cycle.
  - rnd_data beats 11111, 11110, 11100, 11000; rnd_last on the 4th beat; then IDLE one cycle.
- req=4'b1111 held: grants rotate 0001→0010→0100→1000→0001. The LFSR sequence is continuous across bursts, continuing with 10001, 00011, 00110…
- Backpressure: ready low for 3 cycles on beat 2 → data 11110 held stable and no LFSR step; resumes on ready.
- cfg_load seed=5'b00000 in IDLE → cfg_err pulse, LFSR unchanged. Seed 5'b10101 → next burst starts with 10101. Load during RUN → cfg_err and no disturbance.
- Free-run 31 accepted beats from 11111 → all 31 nonzero values seen exactly once; beat 32 = 11111.
- Assert reset mid-burst (beat 2) → grant/rnd_valid drop immediately; after release, req[3] and req[0] both high → req[0] is granted first.
